// File: rtl/sd_cmd_master_arb_pkg.sv
// Shared definitions for the SD command-side scheduler.
// State encodings, status phase codes and SETTING/STATUS field positions.
package sd_cmd_master_arb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ISSUE = 4'b0010,
        ST_SERVE = 4'b0100,
        ST_CLOSE = 4'b1000
    } state_t;

    localparam logic [3:0] PH_WR     = 4'd1;
    localparam logic [3:0] PH_WO     = 4'd2;
    localparam logic [3:0] PH_DLY_WR = 4'd3;
    localparam logic [3:0] PH_DLY_WO = 4'd4;
    localparam logic [3:0] PH_READ   = 4'd5;
    localparam logic [3:0] PH_DONE   = 4'd6;

    localparam int STS_FINAL = 6;
    localparam int STS_CRCOK = 5;
    localparam int STS_PH_MSB = 3;

    localparam int SET_RSZ_MSB = 6;
    localparam int SET_CRC     = 7;
    localparam int SET_DLY_LSB = 8;
    localparam int SET_BLK_LSB = 11;
    localparam int SET_WSEL_LSB = 13;

    // A command expects a response whenever its response size is non-zero.
    function automatic logic has_resp(input logic [15:0] setting);
        return |setting[SET_RSZ_MSB:0];
    endfunction

endpackage

// File: rtl/sd_cmd_master_arb_rr_arb2.sv
// Two-way round-robin arbiter for the command scheduler.
// When both request, the requester not granted last wins; before any grant, 0 wins.
import sd_cmd_master_arb_pkg::*;

module sd_cmd_rr_arb2 (
    input  logic [1:0] req,
    input  logic       en,
    input  logic       last,
    input  logic       last_vld,
    output logic [1:0] gnt
);

    // Combinational one-hot grant selection
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_vld && !last) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/sd_cmd_master_arb.sv
// Command-side scheduler sharing the CMD line between two requesters.
// Issues the granted command to the serial host and acks each status update.
import sd_cmd_master_arb_pkg::*;

module sd_cmd_master_arb #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic        SD_CLK_IN,
    input  logic        RST_IN,
    input  logic [1:0]  rq_req_i,
    input  logic [15:0] rq0_setting_i,
    input  logic [39:0] rq0_cmd_i,
    input  logic [15:0] rq1_setting_i,
    input  logic [39:0] rq1_cmd_i,
    output logic [1:0]  gnt_o,
    output logic        done_o,
    output logic        done_id_o,
    output logic [39:0] resp_o,
    output logic        crc_ok_o,
    output logic        timeout_o,
    output logic        busy_o,
    output logic [15:0] sh_setting_o,
    output logic [39:0] sh_cmd_o,
    output logic        sh_req_o,
    output logic        sh_ack_o,
    input  logic        sh_ack_i,
    input  logic        sh_req_i,
    input  logic [7:0]  sh_status_i,
    input  logic [39:0] sh_resp_i
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic            rr_last;
    logic            rr_vld;
    logic            req_d;
    logic [TO_W-1:0] to_cnt;
    logic [39:0]     resp_q;
    logic            crc_q;
    logic [1:0]      arb_gnt;
    logic            arb_en;
    logic            req_rise;
    logic            sts_final;
    logic            sts_phase;
    logic            crc_now;
    logic            to_hit;

    assign arb_en    = (state == ST_IDLE) && sh_ack_i;
    assign req_rise  = sh_req_i && !req_d;
    assign sts_final = sh_status_i[STS_FINAL];
    assign sts_phase = |sh_status_i[STS_PH_MSB:0];
    assign crc_now   = has_resp(sh_setting_o) ? sh_status_i[STS_CRCOK] : 1'b1;
    assign to_hit    = (state != ST_IDLE) && (to_cnt == TO_LAST);

    sd_cmd_rr_arb2 u_arb (
        .req      (rq_req_i),
        .en       (arb_en),
        .last     (rr_last),
        .last_vld (rr_vld),
        .gnt      (arb_gnt)
    );

    // Scheduler FSM with registered outputs; timeout overrides any state
    always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state        <= ST_IDLE;
            rr_last      <= 1'b0;
            rr_vld       <= 1'b0;
            req_d        <= 1'b0;
            to_cnt       <= '0;
            resp_q       <= '0;
            crc_q        <= 1'b0;
            gnt_o        <= 2'b00;
            done_o       <= 1'b0;
            done_id_o    <= 1'b0;
            resp_o       <= '0;
            crc_ok_o     <= 1'b0;
            timeout_o    <= 1'b0;
            busy_o       <= 1'b0;
            sh_setting_o <= '0;
            sh_cmd_o     <= '0;
            sh_req_o     <= 1'b0;
            sh_ack_o     <= 1'b0;
        end else begin
            req_d  <= sh_req_i;
            done_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (|arb_gnt) begin
                        sh_setting_o <= arb_gnt[1] ? rq1_setting_i : rq0_setting_i;
                        sh_cmd_o     <= arb_gnt[1] ? rq1_cmd_i : rq0_cmd_i;
                        gnt_o        <= arb_gnt;
                        rr_last      <= arb_gnt[1];
                        rr_vld       <= 1'b1;
                        to_cnt       <= '0;
                        sh_req_o     <= 1'b1;
                        busy_o       <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (req_rise && sts_phase) begin
                        sh_req_o <= 1'b0;
                        sh_ack_o <= 1'b1;
                        if (sts_final) begin
                            resp_q <= sh_resp_i;
                            crc_q  <= crc_now;
                            state  <= ST_CLOSE;
                        end else begin
                            state  <= ST_SERVE;
                        end
                    end
                end
                ST_SERVE: begin
                    to_cnt   <= to_cnt + 1'b1;
                    sh_ack_o <= sh_req_i;
                    if (req_rise && sts_final) begin
                        resp_q   <= sh_resp_i;
                        crc_q    <= crc_now;
                        sh_ack_o <= 1'b1;
                        state    <= ST_CLOSE;
                    end
                end
                ST_CLOSE: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (sh_ack_i) begin
                        sh_ack_o  <= 1'b0;
                        done_o    <= 1'b1;
                        done_id_o <= rr_last;
                        timeout_o <= 1'b0;
                        gnt_o     <= 2'b00;
                        resp_o    <= resp_q;
                        crc_ok_o  <= crc_q;
                        busy_o    <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            if (to_hit) begin
                done_o    <= 1'b1;
                done_id_o <= rr_last;
                timeout_o <= 1'b1;
                crc_ok_o  <= 1'b0;
                sh_req_o  <= 1'b0;
                sh_ack_o  <= 1'b0;
                gnt_o     <= 2'b00;
                busy_o    <= 1'b0;
                state     <= ST_IDLE;
            end
        end
    end

endmodule
